// File: rtl/gumnut_bus_pkg.sv
// Shared types for the Gumnut data-memory/IO bus: arbiter states, master
// indices and the Wishbone-style request bundle.
package gumnut_bus_pkg;

  localparam int GB_ADDR_W = 8;
  localparam int GB_DATA_W = 8;

  localparam int M0_IDX = 0;
  localparam int M1_IDX = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } arb_state_t;

  // Field widths are fixed at the native Gumnut bus width.
  typedef struct packed {
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [GB_ADDR_W-1:0] adr;
    logic [GB_DATA_W-1:0] dat;
  } wb_req_t;

  function automatic logic req_active(input wb_req_t r);
    return r.cyc & r.stb;
  endfunction

endpackage

// File: rtl/gumnut_bus_watchdog.sv
// Stall counter for the bus arbiter: counts cycles an owner strobe waits for
// ack and flags the last allowed cycle. TIMEOUT=0 never expires.
module gumnut_bus_watchdog
  import gumnut_bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);

  logic [7:0] wd_cnt;

  assign expired_o = (TIMEOUT != 0) && (wd_cnt == 8'(TIMEOUT - 1));

  // Expiry also clears so the count starts fresh for the next owner.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wd_cnt <= 8'd0;
    end else if (clr_i || expired_o) begin
      wd_cnt <= 8'd0;
    end else if (inc_i && (wd_cnt != 8'hFF)) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/gumnut_bus_arbiter.sv
// Two-master, one-slave arbiter for the Gumnut data bus: registered grant,
// round-robin tie-break, cyc-based locking and a stall watchdog.
module gumnut_bus_arbiter
  import gumnut_bus_pkg::*;
#(
  parameter int ADDR_W  = GB_ADDR_W,
  parameter int DATA_W  = GB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o,
  output arb_state_t        dbg_state_o
);

  // Handshake: stb is the request-valid, s_ack_i the completion; a strobe
  // completes in the cycle where stb and ack are both high. cyc brackets a
  // locked burst and is what keeps ownership.

  arb_state_t state, state_nx;
  logic       last_grant, last_grant_nx;   // 1 = M1 was granted last
  wb_req_t    m0_req, m1_req, own_req;
  logic       own_active;
  logic       wd_inc, wd_clr, wd_expired, timeout_err;

  assign m0_req = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i, adr: m0_adr_i, dat: m0_dat_i};
  assign m1_req = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i, adr: m1_adr_i, dat: m1_dat_i};

  assign dbg_state_o = state;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
    end
  end

  always_comb begin
    own_req     = (state == OWN_M1) ? m1_req : m0_req;
    own_active  = (state != IDLE);
    wd_inc      = own_active & own_req.stb & ~s_ack_i;
    wd_clr      = ~own_active | ~own_req.cyc | ~own_req.stb | s_ack_i;
    timeout_err = wd_inc & wd_expired;
  end

  gumnut_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (wd_inc),
    .clr_i     (wd_clr),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    s_cyc_o       = 1'b0;
    s_stb_o       = 1'b0;
    s_we_o        = 1'b0;
    s_adr_o       = '0;
    s_dat_o       = '0;
    m0_ack_o      = 1'b0;
    m0_err_o      = 1'b0;
    m0_dat_o      = '0;
    m1_ack_o      = 1'b0;
    m1_err_o      = 1'b0;
    m1_dat_o      = '0;
    grant_o       = 2'b00;

    if (own_active) begin
      s_cyc_o = own_req.cyc;
      s_stb_o = own_req.stb;
      s_we_o  = own_req.we;
      s_adr_o = own_req.adr;
      s_dat_o = own_req.dat;
    end

    unique case (state)
      IDLE: begin
        // Tie goes to whoever was not granted last.
        if (req_active(m0_req) && (!req_active(m1_req) || last_grant)) begin
          state_nx      = OWN_M0;
          last_grant_nx = 1'b0;
        end else if (req_active(m1_req)) begin
          state_nx      = OWN_M1;
          last_grant_nx = 1'b1;
        end
      end
      OWN_M0: begin
        grant_o[M0_IDX] = 1'b1;
        m0_ack_o        = s_ack_i & m0_stb_i;
        m0_err_o        = timeout_err;
        m0_dat_o        = s_dat_i;
        if (!m0_cyc_i || timeout_err) state_nx = IDLE;
      end
      OWN_M1: begin
        grant_o[M1_IDX] = 1'b1;
        m1_ack_o        = s_ack_i & m1_stb_i;
        m1_err_o        = timeout_err;
        m1_dat_o        = s_dat_i;
        if (!m1_cyc_i || timeout_err) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
